// File: rtl/i8080_intc.sv
// 8080 interrupt controller: eight edge-latched requests, mask, fixed priority, RST n vectoring, ISR nesting.
// Optional INTC_AUTO_EOI_EN: acknowledge clears the request without setting ISR.
module i8080_intc #(
    parameter logic [7:0] IO_BASE  = 8'hF0,
    parameter logic [2:0] SPUR_LVL = 3'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [7:0]  irq,
    input  logic        sync,
    input  logic [7:0]  cpu_do,
    input  logic [15:0] addr,
    input  logic        wr_n,
    input  logic        rd,
    input  logic        inta_n,
    output logic        intr,
    output logic [7:0]  di,
    output logic        di_en
);

    localparam int unsigned NLVL = 8;

    logic [NLVL-1:0] irq_q;
    logic [NLVL-1:0] irr;
    logic [NLVL-1:0] isr;
    logic [NLVL-1:0] imr;
    logic [NLVL-1:0] irr_nxt;
    logic [NLVL-1:0] isr_nxt;
    logic [NLVL-1:0] pend;
    logic [2:0]      lvl;
    logic [3:0]      blk;
    logic            req;
    logic            stat_inta;
    logic            stat_out;
    logic            stat_inp;
    logic [2:0]      vec;
    logic            spur;
    logic            rsel;
    logic            io_match;
    logic            wr_fire;
    logic            imr_wr;
    logic            cmd_wr;
    logic            eoi_ns;
    logic            eoi_s;
    logic            rsel_wr;
    logic            ack;
    logic            unused_addr;

    assign unused_addr = ^addr[15:8];

    // Lowest pending index and lowest in-service index; a request must beat the in-service level.
    always_comb begin
        pend = irr & ~imr;
        lvl  = 3'd0;
        blk  = 4'd8;
        for (int i = NLVL - 1; i >= 0; i--) begin
            if (pend[i]) lvl = 3'(i);
            if (isr[i])  blk = 4'(i);
        end
        req = (pend != '0) && ({1'b0, lvl} < blk);
    end

    assign io_match = (addr[7:1] == IO_BASE[7:1]);
    assign wr_fire  = ce && !wr_n && stat_out && io_match;
    assign imr_wr   = wr_fire && !addr[0];
    assign cmd_wr   = wr_fire && addr[0];
    assign eoi_ns   = cmd_wr && cpu_do[5] && !cpu_do[6];
    assign eoi_s    = cmd_wr && cpu_do[5] && cpu_do[6];
    assign rsel_wr  = cmd_wr && !cpu_do[5] && cpu_do[3];
    assign ack      = ce && !inta_n && stat_inta && !spur;

    // Acknowledge clears the vectored request, but a fresh edge in the same cycle re-latches it.
    always_comb begin
        irr_nxt = irr;
        if (ack) irr_nxt[vec] = 1'b0;
        irr_nxt = irr_nxt | (irq & ~irq_q);

        isr_nxt = isr;
        if (eoi_ns) isr_nxt = isr & (isr - 8'd1);
        if (eoi_s)  isr_nxt[cpu_do[2:0]] = 1'b0;
`ifdef INTC_AUTO_EOI_EN
`else
        if (ack)    isr_nxt[vec] = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q     <= '0;
            irr       <= '0;
            isr       <= '0;
            imr       <= 8'hFF;
            intr      <= 1'b0;
            stat_inta <= 1'b0;
            stat_out  <= 1'b0;
            stat_inp  <= 1'b0;
            vec       <= 3'd0;
            spur      <= 1'b0;
            rsel      <= 1'b0;
        end else if (ce) begin
            irq_q <= irq;
            irr   <= irr_nxt;
            isr   <= isr_nxt;
            intr  <= req;
            if (imr_wr)  imr  <= cpu_do;
            if (rsel_wr) rsel <= cpu_do[0];
            if (sync) begin
                stat_inta <= cpu_do[0];
                stat_out  <= cpu_do[4];
                stat_inp  <= cpu_do[6];
                // Vector is frozen at the INTA status so later mask writes cannot alter it.
                if (cpu_do[0]) begin
                    vec  <= req ? lvl : SPUR_LVL;
                    spur <= !req;
                end
            end
        end
    end

    // Read-bus drive: RST opcode during acknowledge, register readback during IN.
    always_comb begin
        di    = 8'hFF;
        di_en = 1'b0;
        if (stat_inta && !inta_n) begin
            di    = {2'b11, vec, 3'b111};
            di_en = 1'b1;
        end else if (stat_inp && rd && io_match) begin
            di_en = 1'b1;
            if (addr[0]) di = rsel ? irr : isr;
            else         di = imr;
        end
    end

endmodule

// File: tb/tb_i8080_intc.sv
// Self-checking bench for i8080_intc: CPU bus cycles driven by tasks, read data checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_i8080_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [7:0]  irq;
    logic        sync;
    logic [7:0]  cpu_do;
    logic [15:0] addr;
    logic        wr_n;
    logic        rd;
    logic        inta_n;
    logic        intr;
    logic [7:0]  di;
    logic        di_en;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

`ifdef INTC_AUTO_EOI_EN
    localparam bit AE = 1'b1;
`else
    localparam bit AE = 1'b0;
`endif

    i8080_intc dut (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .irq    (irq),
        .sync   (sync),
        .cpu_do (cpu_do),
        .addr   (addr),
        .wr_n   (wr_n),
        .rd     (rd),
        .inta_n (inta_n),
        .intr   (intr),
        .di     (di),
        .di_en  (di_en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic status(input logic [7:0] st);
        sync   = 1'b1;
        cpu_do = st;
        step();
        sync   = 1'b0;
        cpu_do = 8'h00;
    endtask

    task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
        status(8'h10);
        addr   = {8'h00, port};
        cpu_do = data;
        wr_n   = 1'b0;
        step();
        wr_n   = 1'b1;
        cpu_do = 8'h00;
    endtask

    task automatic io_rd(input string tag, input logic [7:0] port,
                         input logic [7:0] exp, input logic en);
        exp_q.push_back(exp);
        status(8'h40);
        addr = {8'h00, port};
        rd   = 1'b1;
        #1;
        check({tag, "_en"}, 8'(di_en), 8'(en));
        check(tag, di, exp_q.pop_front());
        step();
        rd = 1'b0;
    endtask

    task automatic inta(input string tag, input logic [7:0] exp, input logic [7:0] edge_irq);
        exp_q.push_back(exp);
        status(8'h23);
        inta_n = 1'b0;
        irq    = edge_irq;
        #1;
        check({tag, "_en"}, 8'(di_en), 8'h01);
        check(tag, di, exp_q.pop_front());
        step();
        inta_n = 1'b1;
        irq    = 8'h00;
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq = bits;
        step();
        irq = 8'h00;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; irq = 8'h00; sync = 1'b0; cpu_do = 8'h00;
        addr = 16'h0000; wr_n = 1'b1; rd = 1'b0; inta_n = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // reset state
        check("rst_intr", 8'(intr), 8'h00);
        check("rst_di_en", 8'(di_en), 8'h00);
        check("rst_di", di, 8'hFF);
        io_rd("rst_imr", 8'hF0, 8'hFF, 1'b1);
        io_rd("rst_isr", 8'hF1, 8'h00, 1'b1);

        // 1: single request, one-ce latency to intr
        io_wr(8'hF0, 8'hFB);
        irq = 8'h04;
        step();
        irq = 8'h00;
        check("t1_intr_lat", 8'(intr), 8'h00);
        step();
        check("t1_intr", 8'(intr), 8'h01);
        inta("t1_vec", 8'hD7, 8'h00);
        io_rd("t1_isr", 8'hF1, AE ? 8'h00 : 8'h04, 1'b1);
        io_wr(8'hF1, 8'h09);
        io_rd("t1_irr", 8'hF1, 8'h00, 1'b1);
        io_wr(8'hF1, 8'h08);
        io_wr(8'hF1, 8'h20);

        // 2: simultaneous edges, lower index wins
        io_wr(8'hF0, 8'h00);
        pulse(8'h28);
        step();
        check("t2_intr", 8'(intr), 8'h01);
        inta("t2_vec", 8'hDF, 8'h00);
        io_wr(8'hF0, 8'h20);

`ifndef INTC_AUTO_EOI_EN
        // 3: nesting with level 3 in service
        pulse(8'h40);
        step();
        check("t3_blocked", 8'(intr), 8'h00);
        pulse(8'h02);
        step();
        check("t3_nest_intr", 8'(intr), 8'h01);
        inta("t3_vec", 8'hCF, 8'h00);
        io_rd("t3_isr_a", 8'hF1, 8'h0A, 1'b1);
        io_wr(8'hF1, 8'h20);
        io_rd("t3_isr_b", 8'hF1, 8'h08, 1'b1);
        io_wr(8'hF1, 8'h63);
        step();
        check("t3_unblock", 8'(intr), 8'h01);
        inta("t3_vec6", 8'hF7, 8'h00);
        io_wr(8'hF1, 8'h20);
`endif

        // 4: spurious acknowledge
        step();
        check("t4_intr", 8'(intr), 8'h00);
        inta("t4_spur", 8'hFF, 8'h00);
        io_rd("t4_isr", 8'hF1, 8'h00, 1'b1);
        io_wr(8'hF1, 8'h09);
        io_rd("t4_irr", 8'hF1, 8'h20, 1'b1);
        io_wr(8'hF1, 8'h08);

        // 5: readback and decode
        io_wr(8'hF0, 8'hA5);
        io_rd("t5_imr", 8'hF0, 8'hA5, 1'b1);
        io_wr(8'h12, 8'h00);
        io_rd("t5_imr_keep", 8'hF0, 8'hA5, 1'b1);
        io_wr(8'hF1, 8'h09);
        io_rd("t5_irr", 8'hF1, 8'h20, 1'b1);
        io_rd("t5_nomatch", 8'h12, 8'hFF, 1'b0);
        io_wr(8'hF1, 8'h00);
        io_rd("t5_ignored", 8'hF1, 8'h20, 1'b1);
        io_wr(8'hF1, 8'h08);

        // 6: level 4, then level 7 with or without auto-EOI
        io_wr(8'hF0, 8'h20);
        pulse(8'h10);
        step();
        check("t6_intr", 8'(intr), 8'h01);
        inta("t6_vec", 8'hE7, 8'h00);
        io_rd("t6_isr", 8'hF1, AE ? 8'h00 : 8'h10, 1'b1);
        pulse(8'h80);
        step();
        check("t6_intr7", 8'(intr), AE ? 8'h01 : 8'h00);
`ifdef INTC_AUTO_EOI_EN
        inta("t6_vec7", 8'hFF, 8'h00);
        io_wr(8'hF1, 8'h09);
        io_rd("t6_irr", 8'hF1, 8'h20, 1'b1);
        io_wr(8'hF1, 8'h08);
`else
        io_wr(8'hF1, 8'h20);
        step();
        check("t6_intr7_eoi", 8'(intr), 8'h01);
        inta("t6_vec7", 8'hFF, 8'h00);
        io_rd("t6_isr7", 8'hF1, 8'h80, 1'b1);
        io_wr(8'hF1, 8'h20);
`endif

        // 7: new edge during acknowledge keeps the request
        pulse(8'h04);
        step();
        check("t7_intr", 8'(intr), 8'h01);
        inta("t7_vec", 8'hD7, 8'h04);
        io_wr(8'hF1, 8'h09);
        io_rd("t7_irr", 8'hF1, 8'h24, 1'b1);
        io_wr(8'hF1, 8'h08);
        io_rd("t7_isr", 8'hF1, AE ? 8'h00 : 8'h04, 1'b1);

        // 8: asynchronous reset during acknowledge
        status(8'h23);
        inta_n = 1'b0;
        #1;
        check("t8_en_pre", 8'(di_en), 8'h01);
        reset = 1'b1;
        #1;
        check("t8_en_rst", 8'(di_en), 8'h00);
        check("t8_di_rst", di, 8'hFF);
        check("t8_intr_rst", 8'(intr), 8'h00);
        inta_n = 1'b1;
        step();
        reset = 1'b0;
        step();
        io_rd("t8_imr", 8'hF0, 8'hFF, 1'b1);
        io_rd("t8_isr", 8'hF1, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
